// File: rtl/mfp_gpio_pkg.sv
// Shared definitions for the GPIO AHB slave and the pin block: word indices
// of the register map and the bus-side FSM state type.
package mfp_gpio_pkg;

    localparam int unsigned ADDR_LEDR     = 0;
    localparam int unsigned ADDR_LEDG     = 1;
    localparam int unsigned ADDR_SW       = 2;
    localparam int unsigned ADDR_BTN      = 3;
    localparam int unsigned ADDR_7SEG     = 4;
    localparam int unsigned ADDR_BTN_EDGE = 5;
    localparam int unsigned ADDR_IRQ_EN   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_STALL
    } gpio_ahb_state_t;

endpackage

// File: rtl/mfp_gpio_edge_irq.sv
// Button rising-edge capture (write-1-to-clear) plus interrupt enable mask and
// registered interrupt output.
module mfp_gpio_edge_irq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] btn_i,
    input  logic        edge_clr_i,
    input  logic        irq_en_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] btn_edge_o,
    output logic [31:0] irq_en_o,
    output logic        irq_o
);

    logic        primed_q,   primed_d;
    logic [31:0] btn_prev_q, btn_prev_d;
    logic [31:0] btn_edge_q, btn_edge_d;
    logic [31:0] irq_en_q,   irq_en_d;
    logic        irq_q,      irq_d;

    always_comb begin
        primed_d   = 1'b1;
        btn_prev_d = btn_i;
        btn_edge_d = btn_edge_q;
        if (edge_clr_i) begin
            btn_edge_d = btn_edge_d & ~wdata_i;
        end
        // Set is applied after clear so a coincident new edge survives;
        // the unprimed first cycle keeps buttons held through reset quiet.
        if (primed_q) begin
            btn_edge_d = btn_edge_d | (btn_i & ~btn_prev_q);
        end
        irq_en_d = irq_en_we_i ? wdata_i : irq_en_q;
        irq_d    = |(btn_edge_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q   <= 1'b0;
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            primed_q   <= primed_d;
            btn_prev_q <= btn_prev_d;
            btn_edge_q <= btn_edge_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    assign btn_edge_o = btn_edge_q;
    assign irq_en_o   = irq_en_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/mfp_ahb_gpio_slave.sv
// AHB-Lite slave front end for the GPIO pin block: word decode into one-hot
// write strobes, read multiplexing onto HRDATA, and button edge interrupt.
module mfp_ahb_gpio_slave
    import mfp_gpio_pkg::*;
#(
    parameter int GPIO_R = 5,
    parameter int GPIO_W = 5,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     HSEL,
    input  logic                     HWRITE,
    input  logic [1:0]               HTRANS,
    input  logic                     HREADY,
    input  logic [31:0]              HADDR,
    input  logic [31:0]              HWDATA,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    input  logic [GPIO_R-1:0][31:0]  gpio_rd,
    output logic [31:0]              gpio_wd,
    output logic [GPIO_W-1:0]        gpio_we,
    output logic                     irq
);

    // Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY;
    // its data phase completes on the first edge where HREADYOUT is high.
    gpio_ahb_state_t   state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic [ADDR_W-1:0] haddr_idx, mux_idx;
    logic [31:0]       rd_mux;
    logic [31:0]       btn_edge, irq_en;
    logic              accept, wr_phase;
    logic              unused_bits;

    assign haddr_idx   = HADDR[ADDR_W+1:2];
    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign wr_phase    = (state_q == ST_WR);
    assign mux_idx     = (state_q == ST_RD_STALL) ? idx_q : haddr_idx;
    assign unused_bits = &{1'b0, HADDR[31:ADDR_W+2], HADDR[1:0], HTRANS[0]};

    always_comb begin
        rd_mux = '0;
        if (mux_idx == ADDR_W'(ADDR_BTN_EDGE)) rd_mux = btn_edge;
        if (mux_idx == ADDR_W'(ADDR_IRQ_EN))   rd_mux = irq_en;
        for (int i = 0; i < GPIO_R; i++) begin
            if (mux_idx == ADDR_W'(i)) rd_mux = gpio_rd[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE, ST_RD: begin
                if (accept) begin
                    idx_d    = haddr_idx;
                    hrdata_d = rd_mux;
                    state_d  = HWRITE ? ST_WR : ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // The pin block only updates at the end of this cycle, so a read
            // arriving now is deferred one cycle rather than sampled stale.
            ST_WR: begin
                if (accept) begin
                    idx_d   = haddr_idx;
                    state_d = HWRITE ? ST_WR : ST_RD_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_STALL: begin
                hrdata_d = rd_mux;
                state_d  = ST_RD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_comb begin
        gpio_we = '0;
        for (int i = 0; i < GPIO_W; i++) begin
            if (wr_phase && (idx_q == ADDR_W'(i)) &&
                (i != int'(ADDR_SW)) && (i != int'(ADDR_BTN))) begin
                gpio_we[i] = 1'b1;
            end
        end
    end

    mfp_gpio_edge_irq u_edge_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (gpio_rd[ADDR_BTN]),
        .edge_clr_i  (wr_phase && (idx_q == ADDR_W'(ADDR_BTN_EDGE))),
        .irq_en_we_i (wr_phase && (idx_q == ADDR_W'(ADDR_IRQ_EN))),
        .wdata_i     (HWDATA),
        .btn_edge_o  (btn_edge),
        .irq_en_o    (irq_en),
        .irq_o       (irq)
    );

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = (state_q != ST_RD_STALL);
    assign HRESP     = 1'b0;
    assign gpio_wd   = HWDATA;

endmodule

// File: doc/mfp_ahb_gpio_slave.md
# mfp_ahb_gpio_slave

AHB-Lite slave that owns the bus side of the GPIO pin interface. It decodes word addresses into the one-hot `gpio_we` strobes and the `gpio_wd` bus, and multiplexes `gpio_rd` back onto `HRDATA`. It adds a button rising-edge capture register with an interrupt output. It sits between the system AHB-Lite decoder and `mfp_gpio_pin`.

## Interface
- `GPIO_R`, 5: number of readable pin-block words on `gpio_rd`.
- `GPIO_W`, 5: number of writable pin-block words on `gpio_we`.
- `ADDR_W`, 3: word-index width, taken from `HADDR[ADDR_W+1:2]`.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `HSEL`, `HWRITE`  in  1 each: AHB-Lite select and direction.
- `HTRANS`  in  2: only `HTRANS[1]` is used (NONSEQ/SEQ).
- `HREADY`  in  1: bus-wide ready.
- `HADDR`, `HWDATA`  in  32 each.
- `HRDATA`  out  32: read data.
- `HREADYOUT`  out  1: slave ready.
- `HRESP`  out  1: tied 0.
- `gpio_rd`  in  `[GPIO_R-1:0][31:0]`: pin-block read words.
- `gpio_wd`  out  32: write data to the pin block.
- `gpio_we`  out  `GPIO_W`: one-hot write strobes.
- `irq`  out  1: button interrupt.

## Operation
Word index map:
- 0 LEDR, 1 LEDG, 2 SW, 3 BTN, 4 7SEG. These are pin-block words.
- 5 BTN_EDGE, write-1-to-clear (W1C).
- 6 IRQ_EN, read/write.
- 7 unmapped: reads 0, writes dropped.

Transfer handling:
- A transfer is accepted in its address phase when `HSEL & HTRANS[1] & HREADY`. The slave registers `HWRITE` and the index.
- `HSIZE` is ignored. Every write stores the full 32-bit `HWDATA`.
- Write data phase: `gpio_wd = HWDATA` (combinational pass-through). `gpio_we[idx]` is high for exactly that cycle if `idx < GPIO_W` and `idx` is not 2 or 3 (read-only). Writes to 2 or 3 are dropped.

State machine (`IDLE`, `WR`, `RD`, `RD_STALL`):
- `IDLE`/`RD`: on an accepted write go to `WR`. On an accepted read go to `RD`. In both cases `HRDATA <= mux(idx)`, sampled at the address-phase edge.
- `WR`: if a read is accepted in the same cycle, go to `RD_STALL`. No `HRDATA` sample is taken here, so a stale value cannot be returned.
- `RD_STALL`: `HREADYOUT = 0` for one cycle and `HRDATA <= mux(idx)`. The next state is `RD`, with `HREADYOUT = 1`.
- Otherwise `HREADYOUT = 1`, and the FSM returns to `IDLE` when no transfer is accepted.

Read mux:
- `idx < GPIO_R` returns `gpio_rd[idx]`.
- 5 returns `btn_edge`; 6 returns `irq_en`; all other indices return 0.

Edge capture:
- `btn_prev <= gpio_rd[3]` every cycle.
- `btn_edge |= gpio_rd[3] & ~btn_prev`.
- A W1C write to index 5 clears the written 1-bits. If set and clear hit the same bit in the same cycle, set wins.
- Priming: on the first cycle after reset release, `btn_prev` loads without setting any edges. This stops buttons held through reset from raising spurious edges.
- `irq = |(btn_edge & irq_en)`, registered.

## Timing
Reset values:
- `HRDATA` 0, `HREADYOUT` 1, `HRESP` 0, `gpio_we` 0, `irq` 0.
- `btn_edge`, `irq_en`, `btn_prev` all 0; FSM in `IDLE`; primed flag clear.

Latencies:
- Write: `gpio_we` is high in the data phase. The pin register updates at the edge ending the data phase.
- Read: zero wait states. The one exception is a read accepted during a write data phase, which takes exactly 1 wait state.
- Edge to `irq`: a button rising edge seen on `gpio_rd[3]` at edge N sets `btn_edge` at N+1 and `irq` at N+2.

Reset mid-transfer:
- The transfer is abandoned.
- `gpio_we` drops asynchronously with `rst_n`.
- `HREADYOUT` returns to 1.

## Structure
- Package `mfp_gpio_pkg`:
  - index constants `ADDR_LEDR`..`ADDR_7SEG`, `ADDR_BTN_EDGE`, `ADDR_IRQ_EN`;
  - FSM state enum `gpio_ahb_state_t`.
  - `mfp_gpio_pin` imports the same constants.
- One sub-module, `mfp_gpio_edge_irq`: holds prev/prime logic, `btn_edge` with W1C, `irq_en`, and `irq`.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs at their reset values, `HREADYOUT` = 1.
- **Write:** write 0x0000_00A5 to index 0 → `gpio_we` = 5'b00001 for one cycle with `gpio_wd` = 0xA5. A write to index 2 → `gpio_we` = 0.
- **Write-then-read:** write 0x1234 to index 4, immediately followed by a read of index 4 (pin block echoing) → one `HREADYOUT` = 0 cycle, then `HRDATA` = 0x1234.
- **Back-to-back reads:** reads of indices 2, 3 and 7 with `gpio_rd[2]` = 0xF0, `gpio_rd[3]` = 0x3 → `HRDATA` 0xF0, 0x3, 0 with no wait states.
- **Edge and interrupt:** write `irq_en` = 0x1, then raise `gpio_rd[3]` bit 0 → `irq` = 1 two cycles later. Write 0x1 to index 5 in the same cycle as a new rising edge → bit stays set. A W1C write of 0x1 with no new edge → `irq` returns to 0.
- **Prime:** `gpio_rd[3]` = 0xFF held through reset release → `btn_edge` stays 0.
